rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data bits per channel.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default clog2(NCH), channel-index width; derived, never overridden.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mode  input  1  0 = directed select, 1 = round-robin arbitration.
REQ-007 sel  input  SELW  channel index used when mode = 0.
REQ-008 in_valid  input  NCH  per-channel request.
REQ-009 in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_chan  output  SELW  source channel index of out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a clock edge; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 Output register SHALL be loadable when out_valid = 0 or out_ready = 1 ("open").
REQ-017 in_ready[i] SHALL equal grant[i] AND open; grant is combinational from the current in_valid, mode, sel and pointer values.
REQ-018 Mode 0: grant[sel] SHALL equal in_valid[sel]; all other grants SHALL be 0; sel >= NCH SHALL grant nothing.
REQ-019 Mode 1: grant SHALL go to the first requesting channel scanning ptr, ptr+1, ... NCH-1, 0, ... ptr-1 (wrap-around).
REQ-020 On a mode-1 input transfer from channel g, ptr SHALL become (g+1) mod NCH; ptr SHALL NOT change on mode-0 transfers or on idle cycles.
REQ-021 On an input transfer, out_data SHALL load in_data of the granted channel, out_chan SHALL load g, and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-022 Simultaneous output and input transfer in one cycle SHALL replace the word, keeping out_valid = 1 (full throughput, 1 word per cycle).
REQ-023 Output transfer with no input transfer SHALL clear out_valid; out_data and out_chan SHALL hold their values.
REQ-024 While out_valid = 1 and out_ready = 0, out_data, out_chan and out_valid SHALL remain stable, and all in_ready SHALL be 0.
REQ-025 Changes to mode or sel SHALL affect only grants in the same cycle; a word already in the output register SHALL be unaffected.
REQ-026 No requests: all in_ready SHALL be 0 and out_valid SHALL clear after any pending output transfer.

Reset
REQ-027 With rst high at a clock edge: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
REQ-028 While rst is high, in_ready SHALL be all 0 regardless of other inputs.
REQ-029 Reset asserted while out_valid = 1 SHALL discard the held word without an output transfer.

Structure
REQ-030 Shared package rr_arb_mux_pkg SHALL hold the default WIDTH/NCH constants and the MODE_SEL = 0 / MODE_RR = 1 encodings.
REQ-031 Grant logic SHALL be a sub-module rr_grant (inputs req, ptr, mode, sel; output one-hot grant and encoded index); the datapath register and pointer SHALL live in rr_arb_mux.
REQ-032 The implementation SHALL be synthesizable, with no latches and no combinational path from out_ready to out_valid.

Verification
REQ-033 Reset: hold rst for 2 cycles with all in_valid = 1111 -> in_ready = 0000, out_valid = 0, out_data = 0 throughout.
REQ-034 Mode 0, sel = 2, in_valid = 1111, ch2 = 0xCAFE0002, out_ready = 1 -> next cycle out_data = 0xCAFE0002, out_chan = 2; in_ready = 0100 only.
REQ-035 Mode 1, all 4 channels valid continuously, out_ready = 1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-036 Mode 1, ptr = 3, only ch1 valid -> ch1 granted (wrap), ptr becomes 2 after the transfer.
REQ-037 Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data stable and in_ready = 0000; out_ready = 1 -> next word loads in the same cycle.
REQ-038 rst asserted mid-stream with out_valid = 1, out_ready = 0 -> next cycle out_valid = 0 and ptr = 0; first grant after release goes to ch0 when all channels request.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and mode encodings for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int NCH_DEF   = 4;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Channel request/accept bundle plus the registered output handshake.
interface rr_arb_mux_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic                  mode;
   logic [SELW-1:0]       sel;
   logic [NCH-1:0]        in_valid;
   logic [NCH*WIDTH-1:0]  in_data;
   logic [NCH-1:0]        in_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [SELW-1:0]       out_chan;
   logic                  out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/rr_arb_mux_grant.sv
// Combinational grant: directed select or wrap-around round-robin scan from ptr.
module rr_grant import rr_arb_mux_pkg::*; #(
   parameter  int NCH  = NCH_DEF,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] gidx,
   output logic            gvalid
);

   logic            hi_found, lo_found;
   logic [SELW-1:0] hi_idx, lo_idx;

   always_comb begin
      grant    = '0;
      gidx     = '0;
      gvalid   = 1'b0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      if (mode == MODE_RR) begin
         // Wrap-around scan split in two: first requester at or above ptr, else lowest requester.
         for (int unsigned i = 0; i < NCH; i++) begin
            if (req[i] && !hi_found && i >= 32'(ptr)) begin
               hi_found = 1'b1;
               hi_idx   = SELW'(i);
            end
            if (req[i] && !lo_found) begin
               lo_found = 1'b1;
               lo_idx   = SELW'(i);
            end
         end
         gvalid = hi_found || lo_found;
         gidx   = hi_found ? hi_idx : lo_idx;
         if (gvalid) grant[gidx] = 1'b1;
      end else if (32'(sel) < NCH) begin
         if (req[sel]) begin
            gvalid     = 1'b1;
            gidx       = sel;
            grant[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrating N:1 mux with a single registered output stage and round-robin pointer.
module rr_arb_mux import rr_arb_mux_pkg::*; #(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int NCH   = NCH_DEF,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic         clk,
   input  logic         rst,
   rr_arb_mux_if.slave  bus
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_chan_q,  out_chan_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic [NCH-1:0]   grant;
   logic [SELW-1:0]  gidx;
   logic             gvalid;
   logic             open;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;

   rr_grant #(.NCH(NCH)) u_grant (
      .req    (bus.in_valid),
      .ptr    (ptr_q),
      .mode   (bus.mode),
      .sel    (bus.sel),
      .grant  (grant),
      .gidx   (gidx),
      .gvalid (gvalid)
   );

   assign open         = !out_valid_q || bus.out_ready;
   assign xfer         = gvalid && open && !rst;
   assign bus.in_ready = xfer ? grant : '0;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_chan_d  = gidx;
         if (bus.mode == MODE_RR) begin
            ptr_d = (gidx == SELW'(NCH-1)) ? '0 : gidx + SELW'(1);
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed vector table followed by randomized traffic against a behavioural model.
module tb_rr_arb_mux;

   localparam int WIDTH = 32;
   localparam int NCH   = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rr_arb_mux_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  in_valid;
      logic        out_ready;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [1:0]  exp_chan;
      logic [31:0] exp_data;
      logic [1:0]  exp_ptr;
   } vec_t;

   vec_t vecs[20];

   // model state
   logic        m_valid;
   logic [31:0] m_data;
   int          m_chan;
   int          m_ptr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] chword(input int ch);
      logic [31:0] w;
      w = bus.in_data[ch*WIDTH +: WIDTH];
      return w;
   endfunction

   // Scan the request list in priority order starting at the pointer.
   task automatic model_grant(output logic [3:0] gnt, output int g);
      gnt = '0;
      g   = -1;
      if (!rst && (!m_valid || bus.out_ready)) begin
         if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) g = int'(bus.sel);
         end else begin
            for (int k = 0; k < NCH; k++) begin
               int c;
               c = (m_ptr + k) % NCH;
               if (g < 0 && bus.in_valid[c]) g = c;
            end
         end
         if (g >= 0) gnt[g] = 1'b1;
      end
   endtask

   task automatic model_step(input int g);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_chan  = 0;
         m_ptr   = 0;
      end else if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = chword(g);
         m_chan  = g;
         if (bus.mode == 1'b1) m_ptr = (g + 1) % NCH;
      end else if (m_valid && bus.out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.mode      = 1'b0;
      bus.sel       = '0;
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = 32'hCAFE0000 + 32'(i);

      //         rst  md  sel   iv       ordy  rdy      v     ch     data          ptr
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000, 2'd0};
      vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000, 2'd0};
      vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002, 2'd0};
      vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hCAFE0000, 2'd1};
      vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFE0001, 2'd2};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002, 2'd3};
      vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hCAFE0003, 2'd0};
      vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hCAFE0000, 2'd1};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002, 2'd3};
      vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFE0001, 2'd2};
      vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hCAFE0001, 2'd2};
      vecs[11] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hCAFE0001, 2'd2};
      vecs[12] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hCAFE0001, 2'd2};
      vecs[13] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hCAFE0002, 2'd3};
      vecs[14] = '{1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hCAFE0002, 2'd3};
      vecs[15] = '{1'b0, 1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'hCAFE0003, 2'd3};
      vecs[16] = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h00000000, 2'd0};
      vecs[17] = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hCAFE0000, 2'd1};
      vecs[18] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hCAFE0000, 2'd1};
      vecs[19] = '{1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hCAFE0000, 2'd1};

      @(posedge clk);
      #1;
      for (int v = 0; v < 20; v++) begin
         rst           = vecs[v].rst;
         bus.mode      = vecs[v].mode;
         bus.sel       = vecs[v].sel;
         bus.in_valid  = vecs[v].in_valid;
         bus.out_ready = vecs[v].out_ready;
         #1;
         check($sformatf("vec%0d in_ready", v), 32'(bus.in_ready), 32'(vecs[v].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", v), 32'(bus.out_valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d out_chan", v), 32'(bus.out_chan), 32'(vecs[v].exp_chan));
         check($sformatf("vec%0d out_data", v), bus.out_data, vecs[v].exp_data);
         check($sformatf("vec%0d ptr", v), 32'(dut.ptr_q), 32'(vecs[v].exp_ptr));
      end

      // Randomized traffic; the first cycle is a reset so the model starts in sync.
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = 0;
      for (int n = 0; n < 500; n++) begin
         logic [3:0] gnt;
         int         g;
         rst           = (n == 0) || ($urandom_range(0, 39) == 0);
         bus.mode      = 1'($urandom_range(0, 1));
         bus.sel       = 2'($urandom_range(0, 3));
         bus.in_valid  = 4'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NCH; i++) bus.in_data[i*WIDTH +: WIDTH] = $urandom;
         #1;
         model_grant(gnt, g);
         check("rand in_ready", 32'(bus.in_ready), 32'(gnt));
         @(posedge clk);
         model_step(g);
         #1;
         check("rand out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("rand out_chan", 32'(bus.out_chan), 32'(m_chan));
         check("rand out_data", bus.out_data, m_data);
         check("rand ptr", 32'(dut.ptr_q), 32'(m_ptr));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
